// File: rtl/key_event_decoder.sv
// Turns the debounced key level into one-cycle gesture events: short press,
// double click, long press and hold auto-repeat, plus a registered busy level.
module key_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 12_500_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_state,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam int MAX_A  = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_C  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_d;
  logic             press_evt, release_evt;
  logic             short_nxt, dclick_nxt, long_nxt, repeat_nxt;

  assign press_evt   = key_d & ~key_state;
  assign release_evt = ~key_d & key_state;

  // State register; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      key_d        <= 1'b1;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      key_d        <= key_state;
      short_press  <= short_nxt;
      double_click <= dclick_nxt;
      long_press   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

  // Next state; a release always takes priority over a terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (press_evt) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (release_evt) begin
          state_nxt = WAIT2;
          cnt_nxt   = '0;
        end else if (cnt == LONG_TC) begin
          state_nxt = LONG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT2: begin
        // A press on the timeout edge starts a fresh gesture instead of a double click.
        if (cnt == DCLICK_TC) begin
          state_nxt = press_evt ? PRESS1 : IDLE;
          cnt_nxt   = '0;
        end else if (press_evt) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESS2: begin
        if (release_evt) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      LONG: begin
        if (release_evt) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_TC) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    short_nxt  = 1'b0;
    dclick_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      PRESS1: long_nxt   = ~release_evt && (cnt == LONG_TC);
      WAIT2:  short_nxt  = (cnt == DCLICK_TC);
      PRESS2: dclick_nxt = release_evt;
      LONG:   repeat_nxt = ~release_evt && (cnt == REPEAT_TC);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: key waveforms are driven per clock and the
// outputs compared against a gesture-level timing model of the event rules.
module tb_key_event_decoder;

  localparam int LONG   = 20;
  localparam int DCLICK = 10;
  localparam int REP    = 5;
  localparam int MAXN   = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_state = 1'b1;
  logic short_press, double_click, long_press, repeat_pulse, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus and result arrays; output bit order {short,dclick,long,repeat,busy}.
  logic       lvl [MAXN];
  logic [4:0] exp_ev [MAXN];
  logic [4:0] obs_ev [MAXN];

  key_event_decoder #(
    .LONG_CYCLES  (LONG),
    .DCLICK_CYCLES(DCLICK),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_state   (key_state),
    .short_press (short_press),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {short_press, double_click, long_press, repeat_pulse, busy};
  endfunction

  // Edge search helpers over lvl[], with the level before index 0 taken as released.
  function automatic int next_press(input int from, input int n);
    for (int i = (from < 0 ? 0 : from); i < n; i++) begin
      if (lvl[i] == 1'b0 && (i == 0 || lvl[i-1] == 1'b1)) return i;
    end
    return -1;
  endfunction

  function automatic int next_release(input int from, input int n);
    for (int i = (from < 1 ? 1 : from); i < n; i++) begin
      if (lvl[i] == 1'b1 && lvl[i-1] == 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic void mark_busy(input int a, input int b, input int n);
    for (int t = a; t <= b && t < n; t++) exp_ev[t][0] = 1'b1;
  endfunction

  // Gesture-level model: walk press/release edge times and place each event.
  function automatic void build_expected(input int n);
    int from, p, r, p2, r2;
    for (int i = 0; i < n; i++) exp_ev[i] = 5'b0;
    from = 0;
    forever begin
      p = next_press(from, n);
      if (p < 0) break;
      r = next_release(p + 1, n);
      if (r < 0 || r > p + LONG) begin
        int end_t;
        end_t = (r < 0) ? n : r;
        if (p + LONG < end_t) exp_ev[p + LONG][2] = 1'b1;
        for (int t = p + LONG + REP; t < end_t; t += REP) exp_ev[t][1] = 1'b1;
        mark_busy(p, end_t - 1, n);
        if (r < 0) break;
        from = r + 1;
      end else begin
        p2 = next_press(r + 1, n);
        if (p2 >= 0 && p2 < r + DCLICK) begin
          r2 = next_release(p2 + 1, n);
          if (r2 < 0) begin
            mark_busy(p, n - 1, n);
            break;
          end
          exp_ev[r2][3] = 1'b1;
          mark_busy(p, r2 - 1, n);
          from = r2 + 1;
        end else begin
          if (r + DCLICK < n) exp_ev[r + DCLICK][4] = 1'b1;
          mark_busy(p, r + DCLICK - 1, n);
          from = r + DCLICK;
        end
      end
    end
  endfunction

  task automatic do_reset(input logic key_lvl);
    @(negedge clk);
    rst = 1'b1;
    key_state = key_lvl;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Apply lvl[i] for clock edge i and capture the outputs at the following negedge.
  task automatic drive_wave(input int n);
    for (int i = 0; i < n; i++) begin
      key_state = lvl[i];
      @(posedge clk);
      @(negedge clk);
      obs_ev[i] = outs();
    end
  endtask

  task automatic fill(input int a, input int b, input logic v);
    for (int i = a; i <= b; i++) lvl[i] = v;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_state = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (outs() !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 00000", i, outs());
      end
    end
    rst = 1'b0;
    key_state = 1'b1;
  endtask

  task automatic test_short_press();
    int n = 30;
    do_reset(1'b1);
    fill(0, n - 1, 1'b1);
    fill(2, 6, 1'b0);
    build_expected(n);
    drive_wave(n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL short_press cycle %0d: got %b expected %b", i, obs_ev[i], exp_ev[i]);
      end
    end
    n_checks++;
    if (obs_ev[17] !== 5'b10000 || obs_ev[18] !== 5'b00000) begin
      n_fail++;
      $display("FAIL short_press_timing: got %b/%b expected 10000/00000", obs_ev[17], obs_ev[18]);
    end
  endtask

  task automatic test_double_click();
    int n = 30;
    do_reset(1'b1);
    fill(0, n - 1, 1'b1);
    fill(2, 6, 1'b0);
    fill(11, 15, 1'b0);
    build_expected(n);
    drive_wave(n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL double_click cycle %0d: got %b expected %b", i, obs_ev[i], exp_ev[i]);
      end
    end
    n_checks++;
    if (obs_ev[16] !== 5'b01000) begin
      n_fail++;
      $display("FAIL double_click_timing: got %b expected 01000", obs_ev[16]);
    end
  endtask

  task automatic test_long_repeat();
    int n = 50;
    do_reset(1'b1);
    fill(0, n - 1, 1'b1);
    fill(2, 43, 1'b0);
    build_expected(n);
    drive_wave(n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL long_repeat cycle %0d: got %b expected %b", i, obs_ev[i], exp_ev[i]);
      end
    end
    n_checks++;
    if (obs_ev[22] !== 5'b00101 || obs_ev[42] !== 5'b00011 || obs_ev[44] !== 5'b00000) begin
      n_fail++;
      $display("FAIL long_repeat_timing: got %b/%b/%b expected 00101/00011/00000",
               obs_ev[22], obs_ev[42], obs_ev[44]);
    end
  endtask

  task automatic test_timeout_tie();
    int n = 45;
    do_reset(1'b1);
    fill(0, n - 1, 1'b1);
    fill(2, 4, 1'b0);
    fill(15, 37, 1'b0);
    build_expected(n);
    drive_wave(n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL timeout_tie cycle %0d: got %b expected %b", i, obs_ev[i], exp_ev[i]);
      end
    end
    n_checks++;
    if (obs_ev[15] !== 5'b10001 || obs_ev[35] !== 5'b00101) begin
      n_fail++;
      $display("FAIL timeout_tie_timing: got %b/%b expected 10001/00101", obs_ev[15], obs_ev[35]);
    end
  endtask

  task automatic test_reset_mid_gesture();
    int n = 32;
    do_reset(1'b1);
    fill(0, n - 1, 1'b1);
    fill(2, 31, 1'b0);
    build_expected(n);
    drive_wave(n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL pre_reset_long cycle %0d: got %b expected %b", i, obs_ev[i], exp_ev[i]);
      end
    end
    rst = 1'b1;
    key_state = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== 5'b0) begin
        n_fail++;
        $display("FAIL mid_reset_outputs cycle %0d: got %b expected 00000", i, outs());
      end
    end
    rst = 1'b0;
    n = 30;
    fill(0, n - 1, 1'b0);
    build_expected(n);
    drive_wave(n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL post_reset_long cycle %0d: got %b expected %b", i, obs_ev[i], exp_ev[i]);
      end
    end
    n_checks++;
    if (obs_ev[20] !== 5'b00101) begin
      n_fail++;
      $display("FAIL post_reset_long_timing: got %b expected 00101", obs_ev[20]);
    end
  endtask

  task automatic test_release_before_long();
    int n = 40;
    do_reset(1'b1);
    fill(0, n - 1, 1'b1);
    fill(2, 20, 1'b0);
    build_expected(n);
    drive_wave(n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL release_before_long cycle %0d: got %b expected %b", i, obs_ev[i], exp_ev[i]);
      end
    end
    n_checks++;
    if (obs_ev[22] !== 5'b00001 || obs_ev[31] !== 5'b10000) begin
      n_fail++;
      $display("FAIL release_before_long_timing: got %b/%b expected 00001/10000",
               obs_ev[22], obs_ev[31]);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 8; round++) begin
      int n = 400;
      int i = 0;
      do_reset(1'b1);
      while (i < n) begin
        int gap = $urandom_range(1, 14);
        int len = $urandom_range(1, 45);
        for (int k = 0; k < gap && i < n; k++) lvl[i++] = 1'b1;
        for (int k = 0; k < len && i < n; k++) lvl[i++] = 1'b0;
      end
      build_expected(n);
      drive_wave(n);
      for (int j = 0; j < n; j++) begin
        n_checks++;
        if (obs_ev[j] !== exp_ev[j]) begin
          n_fail++;
          $display("FAIL random r%0d cycle %0d: got %b expected %b", round, j, obs_ev[j], exp_ev[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_double_click();
    test_long_repeat();
    test_timeout_tie();
    test_reset_mid_gesture();
    test_release_before_long();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
